// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - BTB write-side controller: coalescing update queue and invalidate walk
module btb_update_ctrl #(
  parameter int INDEX_BITS  = 4,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           upd_valid,
  input  logic [31:0]                    upd_pc,
  input  logic [31:0]                    upd_target,
  output logic                           upd_ready,
  input  logic                           flush_req,
  output logic                           flush_busy,
  input  logic                           btb_wr_block,
  output logic                           btb_wr_en,
  output logic [INDEX_BITS-1:0]          btb_wr_index,
  output logic                           btb_wr_valid,
  output logic [31:0]                    btb_wr_tag,
  output logic [31:0]                    btb_wr_target,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  localparam logic [INDEX_BITS-1:0] LAST_INDEX = '1;

  logic [0:0]            state;
  logic [INDEX_BITS-1:0] walk_cnt;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;
  logic [31:0]           q_pc  [QUEUE_DEPTH];
  logic [31:0]           q_tgt [QUEUE_DEPTH];

  logic                  pop;
  logic                  full;
  logic                  hit;
  logic [PW-1:0]         hit_idx;
  logic [PW-1:0]         offs;
  logic                  accept;
  logic                  push;
  logic                  coalesce;

  // Drain the head whenever idle, not flushing this cycle and the port is free
  always_comb begin
    pop  = (state == S_IDLE) && !flush_req && (count != '0) && !btb_wr_block;
    full = (count == CW'(QUEUE_DEPTH));
  end

  // Search live entries for a PC match; the head being popped now is not eligible
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    offs    = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      offs = PW'(i) - head;
      if (({1'b0, offs} < count) && !(pop && (PW'(i) == head)) && (q_pc[i] == upd_pc)) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  // Accept when idle with room, or when the update folds into an existing entry
  always_comb begin
    upd_ready = (state == S_IDLE) && !flush_req && (!full || hit);
    accept    = upd_valid && upd_ready;
    push      = accept && !hit;
    coalesce  = accept && hit;
  end

  // Write port: install from the queue head, or invalidate during the walk
  always_comb begin
    btb_wr_en     = 1'b0;
    btb_wr_valid  = 1'b0;
    btb_wr_index  = '0;
    btb_wr_tag    = '0;
    btb_wr_target = '0;
    if (pop) begin
      btb_wr_en     = 1'b1;
      btb_wr_valid  = 1'b1;
      btb_wr_index  = q_pc[head][INDEX_BITS+1:2];
      btb_wr_tag    = q_pc[head];
      btb_wr_target = q_tgt[head];
    end else if ((state == S_FLUSH) && !btb_wr_block) begin
      btb_wr_en     = 1'b1;
      btb_wr_index  = walk_cnt;
    end
  end

  assign flush_busy  = (state == S_FLUSH);
  assign queue_count = count;

  // Queue payload storage; occupancy is tracked separately so no reset is needed here
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]  <= upd_pc;
      q_tgt[tail] <= upd_target;
    end
    if (coalesce) begin
      q_tgt[hit_idx] <= upd_target;
    end
  end

  // State, walk counter and queue pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      walk_cnt <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (flush_req) begin
            state    <= S_FLUSH;
            walk_cnt <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
          end else begin
            if (pop) begin
              head <= head + PW'(1);
            end
            if (push) begin
              tail <= tail + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
          end
        end
        default: begin
          if (flush_req) begin
            walk_cnt <= '0;
          end else if (!btb_wr_block) begin
            if (walk_cnt == LAST_INDEX) begin
              state    <= S_IDLE;
              walk_cnt <= '0;
            end else begin
              walk_cnt <= walk_cnt + INDEX_BITS'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb/tb_btb_update_ctrl.sv - directed self-checking bench for btb_update_ctrl
module tb_btb_update_ctrl;

  logic        clk;
  logic        rst;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_ready;
  logic        flush_req;
  logic        flush_busy;
  logic        btb_wr_block;
  logic        btb_wr_en;
  logic [3:0]  btb_wr_index;
  logic        btb_wr_valid;
  logic [31:0] btb_wr_tag;
  logic [31:0] btb_wr_target;
  logic [2:0]  queue_count;

  int n_assert;
  int n_fail;

  btb_update_ctrl #(.INDEX_BITS(4), .QUEUE_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_target   (upd_target),
    .upd_ready    (upd_ready),
    .flush_req    (flush_req),
    .flush_busy   (flush_busy),
    .btb_wr_block (btb_wr_block),
    .btb_wr_en    (btb_wr_en),
    .btb_wr_index (btb_wr_index),
    .btb_wr_valid (btb_wr_valid),
    .btb_wr_tag   (btb_wr_tag),
    .btb_wr_target(btb_wr_target),
    .queue_count  (queue_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_install(input string tag, input logic [3:0] idx, input logic [31:0] pc, input logic [31:0] tgt);
    chk({tag, "_en"}, btb_wr_en, 1'b1);
    chk({tag, "_valid"}, btb_wr_valid, 1'b1);
    chk({tag, "_index"}, btb_wr_index, idx);
    chk({tag, "_tag"}, btb_wr_tag, pc);
    chk({tag, "_target"}, btb_wr_target, tgt);
  endtask

  task automatic chk_inval(input string tag, input logic [3:0] idx);
    chk({tag, "_en"}, btb_wr_en, 1'b1);
    chk({tag, "_valid"}, btb_wr_valid, 1'b0);
    chk({tag, "_index"}, btb_wr_index, idx);
    chk({tag, "_tag"}, btb_wr_tag, 32'h0);
    chk({tag, "_busy"}, flush_busy, 1'b1);
    chk({tag, "_ready"}, upd_ready, 1'b0);
  endtask

  logic [31:0] fill_pc [4];
  logic [3:0]  fill_ix [4];
  int          widx;

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    upd_valid    = 1'b0;
    upd_pc       = '0;
    upd_target   = '0;
    flush_req    = 1'b0;
    btb_wr_block = 1'b0;
    fill_pc[0] = 32'h110; fill_ix[0] = 4'd4;
    fill_pc[1] = 32'h120; fill_ix[1] = 4'd8;
    fill_pc[2] = 32'h130; fill_ix[2] = 4'd12;
    fill_pc[3] = 32'h140; fill_ix[3] = 4'd0;

    // reset values
    #2;
    chk("rst_wr_en", btb_wr_en, 1'b0);
    chk("rst_busy", flush_busy, 1'b0);
    chk("rst_count", queue_count, 3'd0);
    chk("rst_ready", upd_ready, 1'b1);
    chk("rst_index", btb_wr_index, 4'd0);
    chk("rst_tag", btb_wr_tag, 32'h0);
    chk("rst_target", btb_wr_target, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // single update
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = 32'h100; upd_target = 32'h200;
    #1;
    chk("single_ready", upd_ready, 1'b1);
    chk("single_nobypass", btb_wr_en, 1'b0);
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    chk("single_count1", queue_count, 3'd1);
    chk_install("single", 4'd0, 32'h100, 32'h200);
    @(negedge clk);
    #1;
    chk("single_count0", queue_count, 3'd0);
    chk("single_idle_en", btb_wr_en, 1'b0);

    // fill while blocked, then drain in order
    btb_wr_block = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      upd_valid = 1'b1; upd_pc = fill_pc[i]; upd_target = 32'h1000 + 32'(i);
      #1;
      chk("fill_ready", upd_ready, 1'b1);
      chk("fill_blocked_en", btb_wr_en, 1'b0);
    end
    @(negedge clk);
    upd_pc = 32'h150;
    #1;
    chk("full_ready", upd_ready, 1'b0);
    chk("full_count", queue_count, 3'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      upd_valid = 1'b0; btb_wr_block = 1'b0;
      #1;
      chk_install("drain", fill_ix[i], fill_pc[i], 32'h1000 + 32'(i));
    end
    @(negedge clk);
    #1;
    chk("drain_done_en", btb_wr_en, 1'b0);
    chk("drain_done_count", queue_count, 3'd0);

    // coalesce into a blocked entry
    btb_wr_block = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h104; upd_target = 32'h300;
    @(negedge clk);
    upd_target = 32'h400;
    #1;
    chk("coal_ready", upd_ready, 1'b1);
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    chk("coal_count", queue_count, 3'd1);
    btb_wr_block = 1'b0;
    #1;
    chk_install("coal", 4'd1, 32'h104, 32'h400);
    @(negedge clk);
    #1;
    chk("coal_single_en", btb_wr_en, 1'b0);
    chk("coal_count0", queue_count, 3'd0);

    // update matching the head being popped this cycle
    btb_wr_block = 1'b1;
    upd_valid = 1'b1; upd_pc = 32'h108; upd_target = 32'h500;
    @(negedge clk);
    upd_target = 32'h600; btb_wr_block = 1'b0;
    #1;
    chk("hp_ready", upd_ready, 1'b1);
    chk_install("hp_old", 4'd2, 32'h108, 32'h500);
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    chk("hp_count", queue_count, 3'd1);
    chk_install("hp_new", 4'd2, 32'h108, 32'h600);
    @(negedge clk);
    #1;
    chk("hp_done_count", queue_count, 3'd0);

    // flush with three pending entries, unblocked walk
    btb_wr_block = 1'b1;
    for (int i = 0; i < 3; i++) begin
      upd_valid = 1'b1; upd_pc = 32'h200 + 32'(4 * i); upd_target = 32'h900;
      @(negedge clk);
    end
    btb_wr_block = 1'b0; flush_req = 1'b1; upd_pc = 32'h20C;
    #1;
    chk("fl_req_ready", upd_ready, 1'b0);
    chk("fl_req_nopop", btb_wr_en, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      flush_req = 1'b0; upd_valid = 1'b0;
      #1;
      chk("fl_count", queue_count, 3'd0);
      chk_inval("fl", 4'(i));
    end
    @(negedge clk);
    #1;
    chk("fl_end_busy", flush_busy, 1'b0);
    chk("fl_end_ready", upd_ready, 1'b1);
    chk("fl_end_en", btb_wr_en, 1'b0);

    // walk with two blocked cycles takes 18 cycles
    flush_req = 1'b1;
    widx = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      flush_req = 1'b0;
      btb_wr_block = (c == 3 || c == 4);
      #1;
      chk("flb_busy", flush_busy, 1'b1);
      if (btb_wr_block) begin
        chk("flb_blocked_en", btb_wr_en, 1'b0);
      end else begin
        chk_inval("flb", 4'(widx));
        widx++;
      end
    end
    @(negedge clk);
    btb_wr_block = 1'b0;
    #1;
    chk("flb_end_busy", flush_busy, 1'b0);

    // flush_req at walk index 7 restarts the walk
    flush_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      flush_req = (i == 7);
      #1;
      chk_inval("flr_pre", 4'(i));
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      flush_req = 1'b0;
      #1;
      chk_inval("flr_post", 4'(i));
    end
    @(negedge clk);
    #1;
    chk("flr_end_busy", flush_busy, 1'b0);

    // async reset at walk index 5
    flush_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      flush_req = 1'b0;
      #1;
      chk_inval("rmf", 4'(i));
    end
    #1;
    rst = 1'b1;
    #1;
    chk("rmf_en", btb_wr_en, 1'b0);
    chk("rmf_busy", flush_busy, 1'b0);
    chk("rmf_count", queue_count, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_target = 32'h700;
    #1;
    chk("rmf_ready", upd_ready, 1'b1);
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    chk_install("rmf_post", 4'd0, 32'h100, 32'h700);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
